univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//   Parametrised universal shift register with command handshake and burst shift count.
//   Accepts one command at a time: parallel load, shift left/right or rotate left/right, N steps.
//   Used wherever serial<->parallel conversion or multi-step bit alignment is needed.
//   Reports busy/done so control FSMs can sequence it.
// PARAMETERS
//   WIDTH  8  register width in bits (>=2)
//   CNT_W  4  width of cmd_count; max burst = 2**CNT_W-1 steps
// PORTS
//   clk        in   1      single clock, rising edge
//   rstn       in   1      asynchronous active-low reset
//   cmd_valid  in   1      command present
//   cmd_ready  out  1      block can accept a command (state IDLE)
//   cmd_mode   in   3      operation code, see usr_pkg
//   cmd_count  in   CNT_W  number of shift/rotate steps (ignored for LOAD)
//   pd         in   WIDTH  parallel load data
//   si         in   1      serial input bit
//   en         in   1      step enable; 0 stalls an in-progress burst
//   out        out  WIDTH  register contents
//   so         out  1      last bit shifted/rotated out
//   busy       out  1      burst in progress
//   done       out  1      one-cycle pulse when command completes
// BEHAVIOUR
//   Reset (rstn=0, async): out=0, so=0, busy=0, done=0, cmd_ready=1, state IDLE, count=0.
//   Accept on edge with cmd_valid && cmd_ready; cmd_ready = (state==IDLE) = ~busy.
//   Modes: 0 NOP, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR; 6,7 treated as NOP.
//   SHL: out <= {out[WIDTH-2:0], si}, so <= out[WIDTH-1]. SHR: out <= {si, out[WIDTH-1:1]}, so <= out[0].
//   ROL/ROR: same as SHL/SHR with si replaced by the bit leaving the register.
//   LOAD/NOP: out <= pd (LOAD only) on accept edge, independent of en; done=1 next cycle; stays IDLE.
//   Shift modes, count N=0: no change; done=1 next cycle; stays IDLE.
//   Shift modes, N>0: accept edge latches mode/N, state SHIFT, busy=1; no step on accept edge.
//     Each later edge with en=1 performs one step, decrements count; en=0 holds out, so, count.
//     Step N at edge k+N (en continuous): done=1 for cycle after it, state IDLE, busy=0, cmd_ready=1.
//   si sampled at each step edge; changes between steps are legal.
//   so holds its value except on step edges; LOAD does not modify so.
//   done never asserted two consecutive cycles; next command may be accepted in done cycle.
//   rstn low mid-burst: abort immediately, all outputs to reset values, no done pulse.
// CONFIGURATION
//   USR_ROTATE_EN defined: ROL/ROR rotate as above.
//   USR_ROTATE_EN undefined: ROL decodes as SHL, ROR as SHR (si fills); no rotate muxing built.
// STRUCTURE
//   usr_pkg: mode localparams (USR_NOP..USR_ROR), state encoding (ST_IDLE, ST_SHIFT).
//   Sub-module usr_shift_step: combinational one-step next-value/next-so from (out, mode, si).
//   Top holds FSM, count register, latched mode, output registers.
// TESTING (WIDTH=8, CNT_W=4)
//   rstn=0 -> out=8'h00, so=0, busy=0, done=0, cmd_ready=1.
//   LOAD pd=8'hA5 -> out=8'hA5 next edge; done=1 one cycle; busy stays 0.
//   from A5, SHL N=3 si=1 en=1 -> out=8'h2F after 3 steps, so=1, done 1 cycle, cmd_ready=0 during.
//   from A5, ROR N=4 -> 8'h5A with USR_ROTATE_EN; without it (si=0) -> 8'h0A.
//   load 8'h80, SHR N=2 si=0, en=0 for 3 cycles after step 1 -> out=8'h20, done 3 cycles later.
//   rstn low during SHIFT -> out=0, IDLE, no done; then SHL N=0 -> done next cycle, out unchanged.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared mode codes and FSM state encoding for the universal shift register.
package usr_pkg;

  localparam logic [2:0] USR_NOP  = 3'd0;
  localparam logic [2:0] USR_LOAD = 3'd1;
  localparam logic [2:0] USR_SHL  = 3'd2;
  localparam logic [2:0] USR_SHR  = 3'd3;
  localparam logic [2:0] USR_ROL  = 3'd4;
  localparam logic [2:0] USR_ROR  = 3'd5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } usr_state_t;

  // True for the four modes that run a multi-step burst.
  function automatic logic is_shift_mode(input logic [2:0] mode);
    return (mode == USR_SHL) || (mode == USR_SHR) || (mode == USR_ROL) || (mode == USR_ROR);
  endfunction

endpackage

// File: rtl/usr_shift_step.sv
// One combinational shift/rotate step. Rotation muxing exists only when
// USR_ROTATE_EN is defined; otherwise ROL/ROR behave as SHL/SHR.
module usr_shift_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [2:0]       mode,
  input  logic             si,
  output logic [WIDTH-1:0] nxt,
  output logic             nxt_so
);

  logic left;
  logic fill;

  always_comb begin
    left = (mode == USR_SHL) || (mode == USR_ROL);
`ifdef USR_ROTATE_EN
    if (mode == USR_ROL)      fill = cur[WIDTH-1];
    else if (mode == USR_ROR) fill = cur[0];
    else                      fill = si;
`else
    fill = si;
`endif
    if (left) begin
      nxt    = {cur[WIDTH-2:0], fill};
      nxt_so = cur[WIDTH-1];
    end else begin
      nxt    = {fill, cur[WIDTH-1:1]};
      nxt_so = cur[0];
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with command handshake and burst step count.
// Optional rotate support is enabled by defining USR_ROTATE_EN.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] pd,
  input  logic             si,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             so,
  output logic             busy,
  output logic             done
);

  usr_state_t       state;
  logic [CNT_W-1:0] count;
  logic [2:0]       mode_q;
  logic [WIDTH-1:0] step_val;
  logic             step_so;

  usr_shift_step #(.WIDTH(WIDTH)) u_step (
    .cur    (out),
    .mode   (mode_q),
    .si     (si),
    .nxt    (step_val),
    .nxt_so (step_so)
  );

  assign busy      = (state == ST_SHIFT);
  assign cmd_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      count  <= '0;
      mode_q <= USR_NOP;
      out    <= '0;
      so     <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_mode == USR_LOAD) begin
              out  <= pd;
              done <= 1'b1;
            end else if (is_shift_mode(cmd_mode) && (cmd_count != '0)) begin
              // Accept edge only latches the burst; the first step is on the next enabled edge.
              state  <= ST_SHIFT;
              count  <= cmd_count;
              mode_q <= cmd_mode;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (en) begin
            out   <= step_val;
            so    <= step_so;
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed table, hand-written corner
// sequences and a randomized run against an arithmetic reference model.
module tb_univ_shift_reg;

  logic       clk;
  logic       rstn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_mode;
  logic [3:0] cmd_count;
  logic [7:0] pd;
  logic       si;
  logic       en;
  logic [7:0] out;
  logic       so;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_count (cmd_count),
    .pd        (pd),
    .si        (si),
    .en        (en),
    .out       (out),
    .so        (so),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef USR_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  typedef struct {
    logic [2:0] mode;
    logic [3:0] cnt;
    logic [7:0] pd;
    logic       si;
    logic [7:0] exp_out;
    logic       exp_so;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one command with en=1 until done, checking latency, handshake and result.
  task automatic do_cmd(input vec_t v, input int idx);
    int cyc;
    int exp_lat;
    bit is_burst;
    is_burst = (v.mode >= 3'd2) && (v.mode <= 3'd5) && (v.cnt != 4'd0);
    exp_lat  = is_burst ? int'(v.cnt) + 1 : 1;
    cmd_valid = 1'b1; cmd_mode = v.mode; cmd_count = v.cnt; pd = v.pd; si = v.si; en = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cyc = 1;
    if (is_burst) check($sformatf("vec%0d ready_low", idx), int'(cmd_ready), 0);
    else          check($sformatf("vec%0d busy_low", idx), int'(busy), 0);
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    check($sformatf("vec%0d done_seen", idx), int'(done), 1);
    check($sformatf("vec%0d latency", idx), cyc, exp_lat);
    check($sformatf("vec%0d out", idx), int'(out), int'(v.exp_out));
    check($sformatf("vec%0d so", idx), int'(so), int'(v.exp_so));
    tick();
    check($sformatf("vec%0d done_pulse", idx), int'(done), 0);
    $display("[TB] vec%0d mode=%0d n=%0d pd=%02h -> out=%02h so=%0b lat=%0d", idx, v.mode, v.cnt, v.pd, out, so, cyc);
  endtask

  // Reference step computed with plain arithmetic on an 0..255 integer.
  task automatic ref_step(inout int v, inout int s, input int md, input int sin);
    int fill;
    bit left;
    left = (md == 2) || (md == 4);
    fill = sin;
    if (ROT && md == 4) fill = v / 128;
    if (ROT && md == 5) fill = v % 2;
    if (left) begin
      s = v / 128;
      v = (v * 2) % 256 + fill;
    end else begin
      s = v % 2;
      v = v / 2 + fill * 128;
    end
  endtask

  int m_out, m_so, m_busy, m_cnt, m_mode, m_done;

  initial begin
    vecs[0] = '{3'd1, 4'd0, 8'hA5, 1'b0, 8'hA5, 1'b0};
    vecs[1] = '{3'd2, 4'd3, 8'h00, 1'b1, 8'h2F, 1'b1};
    vecs[2] = '{3'd1, 4'd0, 8'hA5, 1'b0, 8'hA5, 1'b1};
    vecs[3] = '{3'd5, 4'd4, 8'h00, 1'b0, ROT ? 8'h5A : 8'h0A, 1'b0};
    vecs[4] = '{3'd0, 4'd5, 8'hFF, 1'b1, ROT ? 8'h5A : 8'h0A, 1'b0};
    vecs[5] = '{3'd2, 4'd0, 8'hFF, 1'b1, ROT ? 8'h5A : 8'h0A, 1'b0};
    vecs[6] = '{3'd7, 4'd9, 8'hFF, 1'b1, ROT ? 8'h5A : 8'h0A, 1'b0};
    vecs[7] = '{3'd1, 4'd0, 8'hC3, 1'b0, 8'hC3, 1'b0};
    vecs[8] = '{3'd4, 4'd2, 8'h00, 1'b0, ROT ? 8'h0F : 8'h0C, 1'b1};

    rstn = 1'b0; cmd_valid = 1'b0; cmd_mode = 3'd0; cmd_count = 4'd0;
    pd = 8'h00; si = 1'b0; en = 1'b0;
    #2;
    check("reset out", int'(out), 0);
    check("reset so", int'(so), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset ready", int'(cmd_ready), 1);
    #10 rstn = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) do_cmd(vecs[i], i);

    // Stall mid-burst: SHR 2 from 0x80 with en low for three cycles after step 1.
    cmd_valid = 1'b1; cmd_mode = 3'd1; pd = 8'h80; tick();
    cmd_mode = 3'd3; cmd_count = 4'd2; si = 1'b0; en = 1'b1; tick();
    cmd_valid = 1'b0; tick();
    check("stall step1 out", int'(out), 8'h40);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall hold%0d out", i), int'(out), 8'h40);
      check($sformatf("stall hold%0d done", i), int'(done), 0);
      check($sformatf("stall hold%0d busy", i), int'(busy), 1);
    end
    en = 1'b1; tick();
    check("stall final out", int'(out), 8'h20);
    check("stall final so", int'(so), 0);
    check("stall final done", int'(done), 1);
    $display("[TB] stall sequence out=%02h done=%0b", out, done);
    tick();

    // Asynchronous reset in the middle of a burst.
    cmd_valid = 1'b1; cmd_mode = 3'd1; pd = 8'hFF; tick();
    cmd_mode = 3'd2; cmd_count = 4'd10; si = 1'b1; tick();
    cmd_valid = 1'b0; tick(); tick();
    rstn = 1'b0; #2;
    check("abort out", int'(out), 0);
    check("abort so", int'(so), 0);
    check("abort busy", int'(busy), 0);
    check("abort ready", int'(cmd_ready), 1);
    #1 rstn = 1'b1;
    tick();
    check("abort no done a", int'(done), 0);
    tick();
    check("abort no done b", int'(done), 0);
    cmd_valid = 1'b1; cmd_mode = 3'd2; cmd_count = 4'd0; tick();
    cmd_valid = 1'b0;
    check("n0 done", int'(done), 1);
    check("n0 out", int'(out), 0);
    check("n0 busy", int'(busy), 0);
    $display("[TB] abort sequence then SHL N=0 out=%02h done=%0b", out, done);
    tick();

    // Randomized run against the reference model.
    m_out = int'(out); m_so = int'(so); m_busy = 0; m_cnt = 0; m_mode = 0; m_done = 0;
    for (int c = 0; c < 400; c++) begin
      int n_done;
      cmd_valid = (m_done == 0) && ($urandom_range(0, 2) != 0);
      cmd_mode  = 3'($urandom_range(0, 7));
      cmd_count = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      pd        = 8'($urandom_range(0, 255));
      si        = 1'($urandom_range(0, 1));
      en        = ($urandom_range(0, 3) != 0);
      n_done = 0;
      if (!m_busy && cmd_valid) begin
        if (cmd_mode == 3'd1) begin
          m_out = int'(pd); n_done = 1;
        end else if (cmd_mode >= 3'd2 && cmd_mode <= 3'd5 && cmd_count != 4'd0) begin
          m_busy = 1; m_cnt = int'(cmd_count); m_mode = int'(cmd_mode);
        end else begin
          n_done = 1;
        end
      end else if (m_busy && en) begin
        ref_step(m_out, m_so, m_mode, int'(si));
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0; n_done = 1;
        end
      end
      m_done = n_done;
      tick();
      check($sformatf("rnd%0d out", c), int'(out), m_out);
      check($sformatf("rnd%0d so", c), int'(so), m_so);
      check($sformatf("rnd%0d busy", c), int'(busy), m_busy);
      check($sformatf("rnd%0d ready", c), int'(cmd_ready), 1 - m_busy);
      check($sformatf("rnd%0d done", c), int'(done), m_done);
      if (done) $display("[TB] rnd%0d command complete out=%02h so=%0b", c, out, so);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
